// File: rtl/cqu_mips_pkg.sv
// Shared types and constants for the register-file write-port logic.
//   REG_ADDR_W / DATA_W / NUM_REGS : register-file geometry
//   arb_state_e                    : write-port arbiter state
//   gnt_src_e                      : which requester owns the port this cycle
//   addr_onehot()                  : register address to one-hot bit mask
package cqu_mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        ARB,
        FORCE
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_MC
    } gnt_src_e;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of the write-port arbiter's handshake and bus signals.
//   master : drives pipeline write-back, multi-cycle issue/result and decode reads
//   slave  : the arbiter; returns mc_ready, busy flags, stall request and the
//            registered register-file write port
interface regfile_wport_arbiter_if;
    import cqu_mips_pkg::*;

    logic                  stall;
    logic                  pipe_we;
    logic [REG_ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0]     pipe_data;
    logic                  mc_issue;
    logic [REG_ADDR_W-1:0] mc_issue_addr;
    logic                  mc_valid;
    logic                  mc_ready;
    logic [REG_ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0]     mc_data;
    logic [REG_ADDR_W-1:0] rd_addr_a;
    logic [REG_ADDR_W-1:0] rd_addr_b;
    logic                  busy_a;
    logic                  busy_b;
    logic                  stall_req;
    logic                  reg_write_en;
    logic [REG_ADDR_W-1:0] reg_write_addr;
    logic [DATA_W-1:0]     reg_write_data;

    modport master (
        output stall, pipe_we, pipe_addr, pipe_data,
        output mc_issue, mc_issue_addr, mc_valid, mc_addr, mc_data,
        output rd_addr_a, rd_addr_b,
        input  mc_ready, busy_a, busy_b, stall_req,
        input  reg_write_en, reg_write_addr, reg_write_data
    );

    modport slave (
        input  stall, pipe_we, pipe_addr, pipe_data,
        input  mc_issue, mc_issue_addr, mc_valid, mc_addr, mc_data,
        input  rd_addr_a, rd_addr_b,
        output mc_ready, busy_a, busy_b, stall_req,
        output reg_write_en, reg_write_addr, reg_write_data
    );

endinterface

// File: rtl/pending_scoreboard.sv
// Per-register pending bits for multi-cycle destinations.
//   clk, rstn          : clock, asynchronous active-low reset
//   i_set_en/i_set_addr: mark a register pending (ignored for $0)
//   i_clr_en/i_clr_addr: retire a pending register
//   i_rd_addr_a/b      : decode source lookups
//   o_busy_a/b         : pending status of the looked-up registers
module pending_scoreboard
    import cqu_mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_a,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_b,
    output logic                  o_busy_a,
    output logic                  o_busy_b
);

    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_pend_d;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    always_comb begin
        w_set_mask = i_set_en ? addr_onehot(i_set_addr) : '0;
        w_clr_mask = i_clr_en ? addr_onehot(i_clr_addr) : '0;
        // Set is applied after clear so a same-cycle set/clear leaves the bit set.
        w_pend_d    = (r_pend & ~w_clr_mask) | w_set_mask;
        w_pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_d;
        end
    end

    assign o_busy_a = r_pend[i_rd_addr_a];
    assign o_busy_b = r_pend[i_rd_addr_b];

    // Re-issuing to a pending register is illegal unless it retires this same cycle.
    a_issue_to_busy: assert property (@(posedge clk) disable iff (!rstn)
        !(i_set_en && (i_set_addr != '0) && r_pend[i_set_addr] &&
          !(i_clr_en && (i_clr_addr == i_set_addr))))
        else $error("mc_issue to already-pending register %0d", i_set_addr);

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the single register-file write port between pipeline write-back and
// a multi-cycle unit, tracks pending multi-cycle destinations and forces a one-cycle
// pipeline stall when the multi-cycle unit has been starved for STARVE_LIMIT cycles.
//   clk, rstn : clock, asynchronous active-low reset
//   io_wp     : slave side of regfile_wport_arbiter_if (requests, busy flags,
//               stall request, registered write port)
module regfile_wport_arbiter
    import cqu_mips_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    regfile_wport_arbiter_if.slave   io_wp
);

    arb_state_e            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_stall_req;
    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0]     r_wdata;

    gnt_src_e              w_gnt;
    logic                  w_pipe_req;
    logic                  w_mc_ready;
    logic                  w_mc_lose;
    logic [REG_ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0]     w_win_data;
    logic                  w_busy_a;
    logic                  w_busy_b;

    always_comb begin
        // The pipeline is held while we force a stall, so its request is masked too.
        w_pipe_req = io_wp.pipe_we & ~io_wp.stall & ~r_stall_req;
        w_gnt      = GNT_NONE;
        unique case (r_state)
            ARB: begin
                if (w_pipe_req) begin
                    w_gnt = GNT_PIPE;
                end else if (io_wp.mc_valid) begin
                    w_gnt = GNT_MC;
                end
            end
            FORCE:   w_gnt = GNT_MC;
            default: w_gnt = GNT_NONE;
        endcase
        w_mc_ready = (w_gnt == GNT_MC);
        w_mc_lose  = io_wp.mc_valid & ~w_mc_ready;
        w_win_addr = (w_gnt == GNT_MC) ? io_wp.mc_addr : io_wp.pipe_addr;
        w_win_data = (w_gnt == GNT_MC) ? io_wp.mc_data : io_wp.pipe_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ARB;
            r_cnt       <= '0;
            r_stall_req <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            // Address/data hold when nobody is granted; only the enable drops.
            if (w_gnt != GNT_NONE) begin
                r_we    <= (w_win_addr != '0);
                r_waddr <= w_win_addr;
                r_wdata <= w_win_data;
            end else begin
                r_we <= 1'b0;
            end

            if (w_mc_lose) begin
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end

            unique case (r_state)
                ARB: begin
                    if (w_mc_lose && (r_cnt == CNT_W'(STARVE_LIMIT - 1))) begin
                        r_state     <= FORCE;
                        r_stall_req <= 1'b1;
                    end
                end
                FORCE: begin
                    r_state     <= ARB;
                    r_stall_req <= 1'b0;
                end
                default: begin
                    r_state     <= ARB;
                    r_stall_req <= 1'b0;
                end
            endcase
        end
    end

    pending_scoreboard u_scoreboard (
        .clk         (clk),
        .rstn        (rstn),
        .i_set_en    (io_wp.mc_issue),
        .i_set_addr  (io_wp.mc_issue_addr),
        .i_clr_en    (w_mc_ready),
        .i_clr_addr  (io_wp.mc_addr),
        .i_rd_addr_a (io_wp.rd_addr_a),
        .i_rd_addr_b (io_wp.rd_addr_b),
        .o_busy_a    (w_busy_a),
        .o_busy_b    (w_busy_b)
    );

    assign io_wp.mc_ready       = w_mc_ready;
    assign io_wp.busy_a         = w_busy_a;
    assign io_wp.busy_b         = w_busy_b;
    assign io_wp.stall_req      = r_stall_req;
    assign io_wp.reg_write_en   = r_we;
    assign io_wp.reg_write_addr = r_waddr;
    assign io_wp.reg_write_data = r_wdata;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter with hand-computed expectations.
module tb_regfile_wport_arbiter;

    logic clk;
    logic rstn;
    int   n_total = 0;
    int   n_bad   = 0;

    regfile_wport_arbiter_if wp ();

    regfile_wport_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_W        (3)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .io_wp (wp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wp.stall         = 1'b0;
        wp.pipe_we       = 1'b0;
        wp.pipe_addr     = '0;
        wp.pipe_data     = '0;
        wp.mc_issue      = 1'b0;
        wp.mc_issue_addr = '0;
        wp.mc_valid      = 1'b0;
        wp.mc_addr       = '0;
        wp.mc_data       = '0;
        wp.rd_addr_a     = '0;
        wp.rd_addr_b     = '0;
    endtask

    initial begin
        idle();
        rstn = 1'b0;

        // Reset with random inputs: everything held at zero.
        for (int i = 0; i < 4; i++) begin
            wp.stall         = 1'($urandom);
            wp.pipe_we       = 1'($urandom);
            wp.pipe_addr     = 5'($urandom);
            wp.pipe_data     = $urandom;
            wp.mc_issue      = 1'($urandom);
            wp.mc_issue_addr = 5'($urandom);
            wp.mc_valid      = 1'($urandom);
            wp.mc_addr       = 5'($urandom);
            wp.mc_data       = $urandom;
            wp.rd_addr_a     = 5'($urandom);
            wp.rd_addr_b     = 5'($urandom);
            tick();
        end
        check("rst_we", 32'(wp.reg_write_en), 32'd0);
        check("rst_addr", 32'(wp.reg_write_addr), 32'd0);
        check("rst_data", wp.reg_write_data, 32'd0);
        check("rst_stall_req", 32'(wp.stall_req), 32'd0);
        check("rst_busy_a", 32'(wp.busy_a), 32'd0);
        check("rst_busy_b", 32'(wp.busy_b), 32'd0);
        idle();
        rstn = 1'b1;
        tick();
        check("post_rst_we", 32'(wp.reg_write_en), 32'd0);

        // Pipeline only.
        wp.pipe_we   = 1'b1;
        wp.pipe_addr = 5'd5;
        wp.pipe_data = 32'hDEADBEEF;
        tick();
        check("pipe_we", 32'(wp.reg_write_en), 32'd1);
        check("pipe_addr", 32'(wp.reg_write_addr), 32'd5);
        check("pipe_data", wp.reg_write_data, 32'hDEADBEEF);
        wp.stall = 1'b1;
        tick();
        check("stalled_we", 32'(wp.reg_write_en), 32'd0);
        check("stalled_addr_hold", 32'(wp.reg_write_addr), 32'd5);
        idle();

        // Pipe write to $0 is dropped.
        wp.pipe_we   = 1'b1;
        wp.pipe_addr = 5'd0;
        wp.pipe_data = 32'h0BAD0BAD;
        tick();
        check("pipe_r0_we", 32'(wp.reg_write_en), 32'd0);
        idle();

        // Contention: pipe first, then mc.
        wp.pipe_we   = 1'b1;
        wp.pipe_addr = 5'd3;
        wp.pipe_data = 32'h33333333;
        wp.mc_valid  = 1'b1;
        wp.mc_addr   = 5'd7;
        wp.mc_data   = 32'h1234;
        #1;
        check("cont_mc_ready0", 32'(wp.mc_ready), 32'd0);
        tick();
        check("cont_pipe_addr", 32'(wp.reg_write_addr), 32'd3);
        check("cont_pipe_data", wp.reg_write_data, 32'h33333333);
        wp.pipe_we = 1'b0;
        #1;
        check("cont_mc_ready1", 32'(wp.mc_ready), 32'd1);
        tick();
        check("cont_mc_we", 32'(wp.reg_write_en), 32'd1);
        check("cont_mc_addr", 32'(wp.reg_write_addr), 32'd7);
        check("cont_mc_data", wp.reg_write_data, 32'h1234);
        idle();
        tick();

        // Starvation: four lost cycles, then one forced cycle.
        wp.pipe_we   = 1'b1;
        wp.pipe_addr = 5'd4;
        wp.pipe_data = 32'h44444444;
        wp.mc_valid  = 1'b1;
        wp.mc_addr   = 5'd10;
        wp.mc_data   = 32'hAAAA;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("starve_ready_%0d", i), 32'(wp.mc_ready), 32'd0);
            check($sformatf("starve_sreq_%0d", i), 32'(wp.stall_req), 32'd0);
            tick();
        end
        check("force_sreq", 32'(wp.stall_req), 32'd1);
        check("force_ready", 32'(wp.mc_ready), 32'd1);
        check("force_pipe_addr", 32'(wp.reg_write_addr), 32'd4);
        tick();
        check("force_mc_we", 32'(wp.reg_write_en), 32'd1);
        check("force_mc_addr", 32'(wp.reg_write_addr), 32'd10);
        check("force_mc_data", wp.reg_write_data, 32'hAAAA);
        // Counter restarted: another full four losing cycles before the next force.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("restart_sreq_%0d", i), 32'(wp.stall_req), 32'd0);
            tick();
        end
        check("restart_force", 32'(wp.stall_req), 32'd1);
        wp.pipe_we = 1'b0;
        tick();
        check("restart_sreq_clr", 32'(wp.stall_req), 32'd0);
        idle();
        tick();

        // Scoreboard set / clear.
        wp.mc_issue      = 1'b1;
        wp.mc_issue_addr = 5'd9;
        wp.rd_addr_a     = 5'd9;
        wp.rd_addr_b     = 5'd10;
        #1;
        check("sb_busy_before", 32'(wp.busy_a), 32'd0);
        tick();
        wp.mc_issue = 1'b0;
        #1;
        check("sb_busy_a_set", 32'(wp.busy_a), 32'd1);
        check("sb_busy_b_clear", 32'(wp.busy_b), 32'd0);
        wp.mc_valid = 1'b1;
        wp.mc_addr  = 5'd9;
        wp.mc_data  = 32'h99;
        #1;
        check("sb_grant_ready", 32'(wp.mc_ready), 32'd1);
        check("sb_busy_in_grant", 32'(wp.busy_a), 32'd1);
        tick();
        check("sb_clr_we", 32'(wp.reg_write_en), 32'd1);
        check("sb_clr_addr", 32'(wp.reg_write_addr), 32'd9);
        check("sb_busy_a_clr", 32'(wp.busy_a), 32'd0);
        wp.mc_valid      = 1'b0;
        wp.mc_issue      = 1'b1;
        wp.mc_issue_addr = 5'd9;
        tick();
        // Simultaneous issue and grant to the same register: stays pending.
        wp.mc_valid = 1'b1;
        tick();
        check("sb_simul_busy", 32'(wp.busy_a), 32'd1);
        check("sb_simul_we", 32'(wp.reg_write_en), 32'd1);
        wp.mc_issue = 1'b0;
        tick();
        check("sb_final_clr", 32'(wp.busy_a), 32'd0);
        idle();

        // mc result to $0: consumed, not written.
        wp.mc_valid = 1'b1;
        wp.mc_addr  = 5'd0;
        wp.mc_data  = 32'h5555;
        #1;
        check("r0_ready", 32'(wp.mc_ready), 32'd1);
        tick();
        check("r0_we", 32'(wp.reg_write_en), 32'd0);
        idle();

        // Pending bits, pipe write to a busy register, then asynchronous reset.
        wp.mc_issue      = 1'b1;
        wp.mc_issue_addr = 5'd12;
        tick();
        wp.mc_issue_addr = 5'd13;
        tick();
        wp.mc_issue  = 1'b0;
        wp.rd_addr_a = 5'd12;
        wp.rd_addr_b = 5'd13;
        wp.pipe_we   = 1'b1;
        wp.pipe_addr = 5'd12;
        wp.pipe_data = 32'hCAFE;
        tick();
        check("mid_pipe_we", 32'(wp.reg_write_en), 32'd1);
        check("mid_busy_a", 32'(wp.busy_a), 32'd1);
        check("mid_busy_b", 32'(wp.busy_b), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_we", 32'(wp.reg_write_en), 32'd0);
        check("async_addr", 32'(wp.reg_write_addr), 32'd0);
        check("async_data", wp.reg_write_data, 32'd0);
        check("async_busy_a", 32'(wp.busy_a), 32'd0);
        check("async_busy_b", 32'(wp.busy_b), 32'd0);
        idle();
        wp.rd_addr_a = 5'd12;
        wp.rd_addr_b = 5'd13;
        tick();
        rstn = 1'b1;
        tick();
        check("after_rst_we", 32'(wp.reg_write_en), 32'd0);
        check("after_rst_busy_a", 32'(wp.busy_a), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
